// File: rtl/nn_pkg.sv
// ============================================================================
//  nn_pkg : shared widths and collector state encoding for the matmul path
//  Revision: 1.0
// ============================================================================
`default_nettype none

package nn_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int N_DEFAULT     = 3;

  // Accumulator width needed to hold an N-term sum of WIDTH x WIDTH products.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } collector_state_t;

endpackage

`default_nettype wire

// File: rtl/row_collector.sv
// ============================================================================
//  row_collector : gathers one row of C from its drain stream, in column order
//  Revision: 1.0
// ============================================================================
`default_nettype none

module row_collector
  import nn_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int ACC_WIDTH = acc_width(WIDTH_DEFAULT, N_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        accept_en,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [ACC_WIDTH-1:0] in_data,
  output logic signed [ACC_WIDTH-1:0] row_data [N],
  output logic                        row_full_next,
  output logic                        overrun
);

  localparam int                CNT_W   = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N);

  logic [CNT_W-1:0] r_col_cnt;
  logic             w_accept;

  assign w_accept = accept_en && in_valid && (r_col_cnt < CNT_MAX);
  // Any strobe not taken is either an extra element or data sent while held.
  assign overrun  = in_valid && !w_accept;
  assign row_full_next = (r_col_cnt == CNT_MAX) ||
                         (w_accept && (r_col_cnt == CNT_MAX - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      for (int j = 0; j < N; j++) row_data[j] <= '0;
    end else begin
      if (clear) begin
        r_col_cnt <= '0;
      end else if (w_accept) begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
      for (int j = 0; j < N; j++) begin
        if (w_accept && (r_col_cnt == CNT_W'(j))) row_data[j] <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_collector.sv
// ============================================================================
//  result_collector : reassembles skewed systolic drain rows into matrix C
//  Revision: 1.0
// ============================================================================
`default_nettype none

module result_collector
  import nn_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int N         = N_DEFAULT,
  parameter int ACC_WIDTH = acc_width(WIDTH, N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0]                in_valid,
  input  logic signed [ACC_WIDTH-1:0] in_data [N],
  output logic                        in_ready,
  output logic                        c_valid,
  input  logic                        c_ready,
  output logic signed [ACC_WIDTH-1:0] matrixC [N][N],
  output logic                        err_overrun
);

  collector_state_t r_state;
  collector_state_t w_state_next;
  logic [N-1:0]     w_row_full_next;
  logic [N-1:0]     w_row_overrun;
  logic             w_accept_en;
  logic             w_clear;

  assign w_accept_en = (r_state == COLLECT);
  assign w_clear     = (r_state == FULL) && c_ready;

  generate
    for (genvar i = 0; i < N; i++) begin : g_row
      row_collector #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_row (
        .clk           (clk),
        .rst_n         (rst_n),
        .accept_en     (w_accept_en),
        .clear         (w_clear),
        .in_valid      (in_valid[i]),
        .in_data       (in_data[i]),
        .row_data      (matrixC[i]),
        .row_full_next (w_row_full_next[i]),
        .overrun       (w_row_overrun[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (&w_row_full_next) w_state_next = FULL;
      FULL:    if (c_ready)          w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  always_comb begin
    in_ready = (r_state == COLLECT);
    c_valid  = (r_state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              err_overrun <= 1'b0;
    else if (|w_row_overrun) err_overrun <= 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// ============================================================================
//  tb_result_collector : directed self-checking bench for result_collector
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_collector;

  localparam int WIDTH     = 16;
  localparam int N         = 3;
  localparam int ACC_WIDTH = 2 * WIDTH + $clog2(N);

  logic                        clk;
  logic                        rst_n;
  logic [N-1:0]                in_valid;
  logic signed [ACC_WIDTH-1:0] in_data [N];
  logic                        in_ready;
  logic                        c_valid;
  logic                        c_ready;
  logic signed [ACC_WIDTH-1:0] matrixC [N][N];
  logic                        err_overrun;

  logic signed [ACC_WIDTH-1:0] exp_c [N][N];
  int n_cmp;
  int n_err;

  result_collector #(
    .WIDTH     (WIDTH),
    .N         (N),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .matrixC     (matrixC),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    c_ready = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_exp(input int sgn);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = ACC_WIDTH'(sgn * (10 * i + j));
  endtask

  task automatic check_matrix(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), matrixC[i][j], exp_c[i][j]);
  endtask

  // Row i drives exp_c[i][*] in cycles i..i+N-1; c_valid must stay low until the end.
  task automatic drive_skew(input int cycles);
    for (int t = 0; t < cycles; t++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = (t >= i) && (t < i + N);
        in_data[i]  = in_valid[i] ? exp_c[i][t-i] : '0;
      end
      tick();
      if (t < 2 * N - 2) check("cv_low_while_draining", c_valid, 1'b0);
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    c_ready = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_c_valid", c_valid, 1'b0);
    check("rst_err", err_overrun, 1'b0);
    check("rst_c00", matrixC[0][0], 0);

    // Skewed stream, completes after 2N-1 cycles
    fill_exp(1);
    drive_skew(2 * N - 1);
    check("skew_c_valid", c_valid, 1'b1);
    check("skew_in_ready", in_ready, 1'b0);
    check_matrix("skew_c");
    check("skew_err", err_overrun, 1'b0);

    // Backpressure while held
    for (int k = 0; k < 4; k++) begin
      in_valid = '1;
      for (int i = 0; i < N; i++) in_data[i] = 99;
      tick();
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_c_valid", c_valid, 1'b1);
    end
    idle_inputs();
    check_matrix("bp_c");
    check("bp_err", err_overrun, 1'b1);
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_c_valid", c_valid, 1'b0);

    // Row overrun: row 0 sends 1..4, rows 1-2 finish in cycles 2..4
    do_reset();
    for (int t = 0; t < 5; t++) begin
      in_valid[0] = (t < 4);
      in_data[0]  = ACC_WIDTH'(t + 1);
      for (int i = 1; i < N; i++) begin
        in_valid[i] = (t >= 2);
        in_data[i]  = ACC_WIDTH'(10 * i + t - 2);
      end
      tick();
      if (t == 3) begin
        check("ovr_err_at_4th", err_overrun, 1'b1);
        check("ovr_cv_early", c_valid, 1'b0);
      end
    end
    idle_inputs();
    check("ovr_c_valid", c_valid, 1'b1);
    for (int j = 0; j < N; j++) check($sformatf("ovr_row0[%0d]", j), matrixC[0][j], j + 1);
    check("ovr_row2_last", matrixC[2][N-1], 20 + N - 1);
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;

    // Back-to-back with c_ready tied high
    do_reset();
    c_ready = 1'b1;
    fill_exp(1);
    drive_skew(2 * N - 1);
    check("b2b_first_cv", c_valid, 1'b1);
    check_matrix("b2b_first");
    tick();
    check("b2b_cv_one_cycle", c_valid, 1'b0);
    check("b2b_in_ready_back", in_ready, 1'b1);
    fill_exp(-1);
    drive_skew(2 * N - 1);
    check("b2b_second_cv", c_valid, 1'b1);
    check_matrix("b2b_second");
    tick();
    check("b2b_second_cv_drop", c_valid, 1'b0);
    c_ready = 1'b0;

    // Reset mid-collection
    fill_exp(1);
    drive_skew(2);
    do_reset();
    check("mid_rst_c_valid", c_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("mid_rst_c[%0d][%0d]", i, j), matrixC[i][j], 0);
    fill_exp(1);
    for (int i = 0; i < N; i++) exp_c[i][0] = ACC_WIDTH'(7 + i);
    drive_skew(2 * N - 1);
    check("mid_rst_fresh_cv", c_valid, 1'b1);
    check_matrix("mid_rst_fresh");
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;

    // Sign and full-width values stored bit-exact
    fill_exp(1);
    exp_c[0][0] = -5;
    exp_c[1][1] = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    exp_c[2][2] = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    drive_skew(2 * N - 1);
    check("sign_cv", c_valid, 1'b1);
    check("sign_neg5", matrixC[0][0], -5);
    check("sign_maxpos", matrixC[1][1], (64'sd1 <<< (ACC_WIDTH - 1)) - 1);
    check("sign_minneg", matrixC[2][2], -(64'sd1 <<< (ACC_WIDTH - 1)));
    check_matrix("sign_c");
    check("sign_err", err_overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
